// File: rtl/mode_sequencer_pkg.sv
// Shared types and wrap-around index arithmetic for the mode sequencer.
package mode_seq_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } press_state_t;

    // Counter/index width for a value range 0..n-1, never narrower than one bit.
    function automatic int ctr_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic int mode_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

    function automatic int mode_dec(input int idx, input int n);
        return (idx == 0) ? n - 1 : idx - 1;
    endfunction

endpackage

// File: rtl/mode_sequencer_btn_debounce.sv
// Two-flop synchroniser followed by a stability-count debouncer.
// Emits the accepted level plus one-cycle rise/fall pulses.
module btn_debounce
    import mode_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 200000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int CW = ctr_width(DEBOUNCE_CYC);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          level_reg;
    logic          rise_reg;
    logic          fall_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CW'(DEBOUNCE_CYC - 1)) begin
                // DEBOUNCE_CYC consecutive differing samples: accept the new level
                level_reg <= sync2_reg;
                rise_reg  <= sync2_reg;
                fall_reg  <= ~sync2_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/mode_sequencer.sv
// Button-driven mode selector: next/prev stepping with wrap, long-press
// toggled auto-cycle, one-hot LED copy and a mode-change strobe.
module mode_sequencer
    import mode_seq_pkg::*;
#(
    parameter  int NUM_MODES    = 7,
    parameter  int DEBOUNCE_CYC = 200000,
    parameter  int LONG_CYC     = 30000000,
    parameter  int AUTO_CYC     = 8000000,
    localparam int MW           = ctr_width(NUM_MODES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 btn_next,
    input  logic                 btn_prev,
    output logic [MW-1:0]        mode,
    output logic [NUM_MODES-1:0] leds,
    output logic                 auto_en,
    output logic                 mode_changed
);
    localparam int HW = ctr_width(LONG_CYC);
    localparam int AW = ctr_width(AUTO_CYC);

    // Index 0 is next, index 1 is prev.
    logic [1:0] btn_raw;
    logic [1:0] btn_level;
    logic [1:0] btn_rise;
    logic [1:0] btn_fall;

    assign btn_raw = {btn_prev, btn_next};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_debounce (
            .clk  (clk),
            .reset(reset),
            .btn  (btn_raw[gi]),
            .level(btn_level[gi]),
            .rise (btn_rise[gi]),
            .fall (btn_fall[gi])
        );
    end

    press_state_t           press_state_reg;
    logic [HW-1:0]          hold_reg;
    logic [AW-1:0]          auto_cnt_reg;
    logic [MW-1:0]          mode_reg;
    logic [NUM_MODES-1:0]   leds_reg;
    logic                   auto_en_reg;
    logic                   mode_changed_reg;

    logic                   next_short;
    logic                   man_inc;
    logic                   man_dec;
    logic                   auto_hit;
    logic                   toggle;
    logic                   btn_active;
    logic                   step;
    logic [MW-1:0]          mode_next;
    logic [NUM_MODES-1:0]   leds_next;

    always_comb begin
        btn_active = (|btn_level) | (|btn_rise);
        next_short = (press_state_reg == PRESSED) && btn_fall[0];
        // Hold counts from the cycle after the debounced rise, so the toggle
        // lands LONG_CYC cycles after the debounced level goes high.
        toggle     = (press_state_reg == PRESSED) && !btn_fall[0]
                     && (hold_reg == HW'(LONG_CYC - 2));
        man_inc    = next_short && !btn_fall[1];
        man_dec    = btn_fall[1] && !next_short;
        auto_hit   = auto_en_reg && !btn_active && (auto_cnt_reg == AW'(AUTO_CYC - 1));
        step       = man_inc || man_dec || auto_hit;
        mode_next  = mode_reg;
        if (man_dec) begin
            mode_next = MW'(mode_dec(int'(mode_reg), NUM_MODES));
        end else if (man_inc || auto_hit) begin
            mode_next = MW'(mode_inc(int'(mode_reg), NUM_MODES));
        end
    end

    for (genvar gi = 0; gi < NUM_MODES; gi++) begin : g_onehot
        assign leds_next[gi] = (mode_next == MW'(gi));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            press_state_reg  <= IDLE;
            hold_reg         <= '0;
            auto_cnt_reg     <= '0;
            mode_reg         <= '0;
            leds_reg         <= NUM_MODES'(1);
            auto_en_reg      <= 1'b0;
            mode_changed_reg <= 1'b0;
        end else begin
            case (press_state_reg)
                IDLE: begin
                    if (btn_rise[0]) begin
                        press_state_reg <= PRESSED;
                        hold_reg        <= '0;
                    end
                end
                PRESSED: begin
                    if (btn_fall[0]) begin
                        press_state_reg <= IDLE;
                    end else if (toggle) begin
                        press_state_reg <= LONG_HELD;
                        auto_en_reg     <= ~auto_en_reg;
                    end else begin
                        hold_reg <= hold_reg + 1'b1;
                    end
                end
                LONG_HELD: begin
                    if (btn_fall[0]) begin
                        press_state_reg <= IDLE;
                    end
                end
                default: press_state_reg <= IDLE;
            endcase

            if (step || toggle || btn_active || !auto_en_reg) begin
                auto_cnt_reg <= '0;
            end else begin
                auto_cnt_reg <= auto_cnt_reg + 1'b1;
            end

            mode_changed_reg <= step;
            if (step) begin
                mode_reg <= mode_next;
                leds_reg <= leds_next;
            end
        end
    end

    assign mode         = mode_reg;
    assign leds         = leds_reg;
    assign auto_en      = auto_en_reg;
    assign mode_changed = mode_changed_reg;

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed bench for mode_sequencer with a cycle-stamped scoreboard of expected mode steps.
module tb_mode_sequencer;
    localparam int NM = 5;
    localparam int DB = 4;
    localparam int LC = 50;
    localparam int AC = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          btn_next;
    logic          btn_prev;
    logic [2:0]    mode;
    logic [NM-1:0] leds;
    logic          auto_en;
    logic          mode_changed;

    mode_sequencer #(
        .NUM_MODES   (NM),
        .DEBOUNCE_CYC(DB),
        .LONG_CYC    (LC),
        .AUTO_CYC    (AC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_next    (btn_next),
        .btn_prev    (btn_prev),
        .mode        (mode),
        .leds        (leds),
        .auto_en     (auto_en),
        .mode_changed(mode_changed)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int mode;
    } exp_t;

    exp_t q[$];
    int   exp_mode = 0;
    int   tests    = 0;
    int   failed   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v)
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Record an expected step landing on clock edge c (dir +1 or -1).
    task automatic push(input int c, input int dir);
        exp_t e;
        exp_mode = (dir > 0) ? (exp_mode + 1) % NM : (exp_mode + NM - 1) % NM;
        e.cyc  = c;
        e.mode = exp_mode;
        q.push_back(e);
        $display("[TB] expect step at cycle %0d -> mode %0d", c, exp_mode);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (q.size() > 0 && q[0].cyc < cyc) begin
                check("missed_step_cycle", cyc, q[0].cyc);
                void'(q.pop_front());
            end
            if (mode_changed) begin
                if (q.size() == 0) begin
                    check("unexpected_strobe", {31'b0, mode_changed}, 0);
                end else begin
                    e = q.pop_front();
                    $display("[TB] strobe cycle %0d mode %0d leds %b", cyc, mode, leds);
                    check("strobe_cycle", cyc, e.cyc);
                    check("strobe_mode", mode, e.mode);
                    check("strobe_leds", leds, 1 << e.mode);
                end
            end
        end
    end

    // Caller is #1 after an edge; press is driven now, release after 'hold' edges.
    task automatic short_press(input int b, input int hold, input bit expect_step);
        int r;
        if (b == 0) btn_next = 1'b1; else btn_prev = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        if (b == 0) btn_next = 1'b0; else btn_prev = 1'b0;
        r = cyc;
        if (expect_step) push(r + 2 + DB + 1, (b == 0) ? 1 : -1);
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic long_next(input logic exp_en, output int rel);
        int p;
        p = cyc;
        btn_next = 1'b1;
        repeat (2 + DB + LC - 1) @(posedge clk);
        #1;
        check("auto_en_before_toggle", auto_en, !exp_en);
        @(posedge clk);
        #1;
        check("auto_en_at_toggle", auto_en, exp_en);
        $display("[TB] long press at %0d toggled auto_en to %0d at %0d", p, auto_en, cyc);
        repeat (80 - (2 + DB + LC)) @(posedge clk);
        #1;
        btn_next = 1'b0;
        rel = cyc;
    endtask

    initial begin
        int r;
        int r3;
        int r4;
        reset    = 1'b1;
        btn_next = 1'b0;
        btn_prev = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_mode", mode, 0);
        check("reset_leds", leds, 1);
        check("reset_auto_en", auto_en, 0);
        check("reset_strobe", mode_changed, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Three clean next presses
        for (int i = 0; i < 3; i++) short_press(0, 10, 1);
        check("t1_mode", mode, 3);
        check("t1_leds", leds, 5'b01000);

        // Wrap in both directions
        short_press(0, 10, 1);
        check("t2_mode4", mode, 4);
        short_press(0, 10, 1);
        check("t2_wrap_up", mode, 0);
        short_press(1, 10, 1);
        check("t2_wrap_down", mode, 4);

        // Glitches shorter than the debounce window, then a real press
        for (int i = 0; i < 2; i++) begin
            btn_next = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            btn_next = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end
        short_press(0, 10, 1);
        check("t3_mode", mode, exp_mode);

        // Long press enables auto-cycle; steps every AUTO_CYC after release
        long_next(1'b1, r);
        for (int k = 0; k < 5; k++) push(r + 2 + DB + AC + k * AC, 1);
        repeat (2 + DB + AC + 4 * AC) @(posedge clk);
        #1;
        check("t4_auto_wrap", mode, 0);
        long_next(1'b0, r);
        repeat (60) @(posedge clk);
        #1;
        check("t4_auto_off", auto_en, 0);
        check("t4_mode_held", mode, exp_mode);

        // prev during auto-cycle: counter held, manual step restarts the period
        long_next(1'b1, r3);
        push(r3 + 2 + DB + AC, 1);
        repeat (2 + DB + AC) @(posedge clk);
        #1;
        r4 = cyc + 10;
        short_press(1, 10, 1);
        push(r4 + 2 + DB + 1 + AC, 1);
        repeat (16) @(posedge clk);
        #1;
        check("t5_mode", mode, exp_mode);
        check("t5_auto_en", auto_en, 1);

        // Reset mid-hold, released under reset
        btn_next = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t6_reset_mode", mode, 0);
        check("t6_reset_leds", leds, 1);
        check("t6_reset_auto_en", auto_en, 0);
        check("t6_reset_strobe", mode_changed, 0);
        repeat (2) @(posedge clk);
        #1;
        btn_next = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        reset    = 1'b0;
        exp_mode = 0;
        repeat (30) @(posedge clk);
        #1;
        check("t6_no_step_after_reset", mode, 0);

        // Coincident next-short and prev releases cancel
        btn_next = 1'b1;
        btn_prev = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        btn_next = 1'b0;
        btn_prev = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("t6_cancel_mode", mode, 0);
        check("t6_cancel_auto_en", auto_en, 0);

        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
